// File: rtl/pulse_burst_pkg.sv
// Shared types and default widths for the pulse burst scheduler.
// This package holds the state encoding, the shadow configuration layout and a
// start-time configuration check.
package pulse_burst_pkg;

   localparam int PULSE_WIDTH_WIDTH_DEF  = 8;
   localparam int PULSE_PERIOD_WIDTH_DEF = 16;
   localparam int COUNT_WIDTH_DEF        = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      RUN  = 2'd2,
      GAP  = 2'd3
   } state_t;

   // Configuration captured on an accepted start. It stays frozen for the
   // whole sequence.
   typedef struct packed {
      logic [PULSE_WIDTH_WIDTH_DEF-1:0]  width;
      logic [PULSE_PERIOD_WIDTH_DEF-1:0] period;
      logic [COUNT_WIDTH_DEF-1:0]        n_pulses;
      logic [COUNT_WIDTH_DEF-1:0]        n_bursts;
      logic [COUNT_WIDTH_DEF-1:0]        gap;
   } shadow_cfg_t;

   // A zero period or a zero pulse count would never reach a burst end.
   function automatic logic cfg_is_valid(
      input logic [PULSE_PERIOD_WIDTH_DEF-1:0] period,
      input logic [COUNT_WIDTH_DEF-1:0]        n_pulses
   );
      return (period != '0) && (n_pulses != '0);
   endfunction

endpackage

// File: rtl/pulse_burst_gap_timer.sv
// Loadable down-counter that times the idle gap between bursts.
// A load takes priority over a decrement. The counter stops at zero, and
// zero is flagged combinationally from the count register.
module pulse_burst_gap_timer
   import pulse_burst_pkg::*;
#(
   parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load,
   input  logic [COUNT_WIDTH-1:0] load_value,
   input  logic                   dec,
   output logic                   zero
);

   localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = 1;

   logic [COUNT_WIDTH-1:0] count;

   // Count register: load, or step down toward zero while enabled.
   // NOTE: clocked state uses non-blocking assignments so that every register
   // samples the values from before the edge, whatever the evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != '0)) begin
         count <= count - COUNT_ONE;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/pulse_burst_scheduler.sv
// Sequences an external pulse_generator through bursts of pulses.
// Completed pulses are counted by watching the generator's cnt output.
// The configuration is shadowed on an accepted start, and all outputs are
// registered.
// With the macro PULSE_BURST_TRIGGER_EN defined, the block gains a trig
// input: ARM then holds until trig is sampled high, and every gap returns
// through ARM.
module pulse_burst_scheduler
   import pulse_burst_pkg::*;
#(
   parameter int PULSE_WIDTH_WIDTH  = PULSE_WIDTH_WIDTH_DEF,
   parameter int PULSE_PERIOD_WIDTH = PULSE_PERIOD_WIDTH_DEF,
   parameter int COUNT_WIDTH        = COUNT_WIDTH_DEF
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          stop,
`ifdef PULSE_BURST_TRIGGER_EN
   input  logic                          trig,
`endif
   input  logic [PULSE_WIDTH_WIDTH-1:0]  cfg_width,
   input  logic [PULSE_PERIOD_WIDTH-1:0] cfg_period,
   input  logic [COUNT_WIDTH-1:0]        cfg_n_pulses,
   input  logic [COUNT_WIDTH-1:0]        cfg_n_bursts,
   input  logic [COUNT_WIDTH-1:0]        cfg_gap,
   input  logic [PULSE_PERIOD_WIDTH-1:0] gen_cnt,
   output logic [PULSE_WIDTH_WIDTH-1:0]  gen_width,
   output logic [PULSE_PERIOD_WIDTH-1:0] gen_period,
   output logic                          gen_rst,
   output logic                          busy,
   output logic                          done,
   output logic                          err,
   output logic [COUNT_WIDTH-1:0]        pulse_cnt,
   output logic [COUNT_WIDTH-1:0]        burst_cnt
);

   localparam logic [PULSE_PERIOD_WIDTH-1:0] PERIOD_ONE = 1;
   localparam logic [COUNT_WIDTH-1:0]        COUNT_ONE  = 1;

`ifdef PULSE_BURST_TRIGGER_EN
   localparam state_t GAP_EXIT = ARM;
`else
   localparam state_t GAP_EXIT = RUN;
`endif

   state_t                 state;
   state_t                 next_state;
   shadow_cfg_t            shadow;
   shadow_cfg_t            shadow_d;
   logic [COUNT_WIDTH-1:0] pulse_cnt_d;
   logic [COUNT_WIDTH-1:0] burst_cnt_d;
   logic [COUNT_WIDTH-1:0] timer_load_value;
   logic                   done_d;
   logic                   err_d;
   logic                   timer_load;
   logic                   timer_dec;
   logic                   timer_zero;
   logic                   arm_go;
   logic                   end_of_period;
   logic                   burst_end;
   logic                   last_burst;

`ifdef PULSE_BURST_TRIGGER_EN
   assign arm_go = trig;
`else
   assign arm_go = 1'b1;
`endif

   // The comparison is made at full width, so a period of 1 ends every cycle.
   assign end_of_period    = (gen_cnt == (shadow.period - PERIOD_ONE));
   assign burst_end        = (pulse_cnt >= (shadow.n_pulses - COUNT_ONE));
   assign last_burst       = (shadow.n_bursts != '0) &&
                             (burst_cnt == (shadow.n_bursts - COUNT_ONE));
   assign timer_load_value = shadow.gap - COUNT_ONE;

   assign gen_width  = shadow.width;
   assign gen_period = shadow.period;

   pulse_burst_gap_timer #(
      .COUNT_WIDTH(COUNT_WIDTH)
   ) u_gap_timer (
      .clk        (clk),
      .rst        (rst),
      .load       (timer_load),
      .load_value (timer_load_value),
      .dec        (timer_dec),
      .zero       (timer_zero)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic, plus the next values of the counters and pulses.
   // NOTE: every signal written here gets a default first; a path that leaves
   // one unassigned would infer a latch.
   always_comb begin
      next_state  = state;
      shadow_d    = shadow;
      pulse_cnt_d = pulse_cnt;
      burst_cnt_d = burst_cnt;
      done_d      = 1'b0;
      err_d       = 1'b0;
      timer_load  = 1'b0;
      timer_dec   = 1'b0;
      case (state)
         IDLE: begin
            // A stop in the same cycle as start wins, and nothing is latched.
            if (start && !stop) begin
               if (!cfg_is_valid(cfg_period, cfg_n_pulses)) begin
                  err_d = 1'b1;
               end else begin
                  shadow_d    = '{width:    cfg_width,
                                  period:   cfg_period,
                                  n_pulses: cfg_n_pulses,
                                  n_bursts: cfg_n_bursts,
                                  gap:      cfg_gap};
                  pulse_cnt_d = '0;
                  burst_cnt_d = '0;
                  next_state  = ARM;
               end
            end
         end
         ARM: begin
            // gen_rst stays high here, which covers the generator's
            // config register.
            if (stop) begin
               next_state = IDLE;
            end else if (arm_go) begin
               next_state = RUN;
            end
         end
         RUN: begin
            if (stop) begin
               next_state = IDLE;
            end else if (end_of_period) begin
               if (!burst_end) begin
                  pulse_cnt_d = pulse_cnt + COUNT_ONE;
               end else begin
                  pulse_cnt_d = '0;
                  burst_cnt_d = burst_cnt + COUNT_ONE;
                  if (last_burst) begin
                     next_state = IDLE;
                     done_d     = 1'b1;
                  end else if (shadow.gap != '0) begin
                     next_state = GAP;
                     timer_load = 1'b1;
                  end
                  // A zero gap stays in RUN. The generator wraps by itself.
               end
            end
         end
         GAP: begin
            if (stop) begin
               next_state = IDLE;
            end else begin
               timer_dec = 1'b1;
               if (timer_zero) begin
                  next_state = GAP_EXIT;
               end
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Registered outputs. gen_rst and busy are decoded from the next state, so
   // they line up with the state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow    <= '0;
         gen_rst   <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         pulse_cnt <= '0;
         burst_cnt <= '0;
      end else begin
         shadow    <= shadow_d;
         gen_rst   <= (next_state != RUN);
         busy      <= (next_state != IDLE);
         done      <= done_d;
         err       <= err_d;
         pulse_cnt <= pulse_cnt_d;
         burst_cnt <= burst_cnt_d;
      end
   end

endmodule

// File: tb/tb_pulse_burst_scheduler.sv
// Testbench for pulse_burst_scheduler.
// A behavioural generator supplies gen_cnt. The reference model builds the
// expected per-cycle output timeline from the burst rules: one ARM cycle,
// then n_pulses*period RUN cycles per burst, then gap cycles, then done.
// The trigger test is built only when PULSE_BURST_TRIGGER_EN is defined.
module tb_pulse_burst_scheduler;

   typedef struct packed {
      logic        busy;
      logic        gen_rst;
      logic        done;
      logic        err;
      logic [15:0] pulse_cnt;
      logic [15:0] burst_cnt;
      logic [7:0]  width;
      logic [15:0] period;
   } obs_t;

   typedef struct {
      int width;
      int period;
      int n_pulses;
      int n_bursts;
      int gap;
   } cfg_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        stop;
`ifdef PULSE_BURST_TRIGGER_EN
   logic        trig;
`endif
   logic [7:0]  cfg_width;
   logic [15:0] cfg_period;
   logic [15:0] cfg_n_pulses;
   logic [15:0] cfg_n_bursts;
   logic [15:0] cfg_gap;
   logic [15:0] gen_cnt = '0;
   logic [7:0]  gen_width;
   logic [15:0] gen_period;
   logic        gen_rst;
   logic        busy;
   logic        done;
   logic        err;
   logic [15:0] pulse_cnt;
   logic [15:0] burst_cnt;

   int   vectors     = 0;
   int   miscompares = 0;
   obs_t tl[$];
   obs_t got[$];
   obs_t hold_exp;
   obs_t reset_exp;

   pulse_burst_scheduler dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .stop         (stop),
`ifdef PULSE_BURST_TRIGGER_EN
      .trig         (trig),
`endif
      .cfg_width    (cfg_width),
      .cfg_period   (cfg_period),
      .cfg_n_pulses (cfg_n_pulses),
      .cfg_n_bursts (cfg_n_bursts),
      .cfg_gap      (cfg_gap),
      .gen_cnt      (gen_cnt),
      .gen_width    (gen_width),
      .gen_period   (gen_period),
      .gen_rst      (gen_rst),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .pulse_cnt    (pulse_cnt),
      .burst_cnt    (burst_cnt)
   );

   always #5 clk = ~clk;

   // Behavioural pulse generator counter: synchronous reset, wraps at
   // period-1.
   always @(posedge clk) begin
      if (gen_rst) gen_cnt <= '0;
      else if (gen_cnt == gen_period - 16'd1) gen_cnt <= '0;
      else gen_cnt <= gen_cnt + 16'd1;
   end

   function automatic obs_t sample();
      obs_t o;
      o.busy = busy; o.gen_rst = gen_rst; o.done = done; o.err = err;
      o.pulse_cnt = pulse_cnt; o.burst_cnt = burst_cnt;
      o.width = gen_width; o.period = gen_period;
      return o;
   endfunction

   function automatic string fmt(obs_t o);
      return $sformatf("busy=%0b gen_rst=%0b done=%0b err=%0b pulse_cnt=%0d burst_cnt=%0d width=%0d period=%0d",
                       o.busy, o.gen_rst, o.done, o.err, o.pulse_cnt, o.burst_cnt, o.width, o.period);
   endfunction

   // Expected outputs for cycles 1.. after the start edge; tl[i] is cycle i+1.
   function automatic void build_model(input cfg_t c, input int stop_at);
      obs_t e;
      obs_t last;
      int   nb_eff;
      int   run_len;
      tl.delete();
      e = '{busy: 1'b1, gen_rst: 1'b1, done: 1'b0, err: 1'b0, pulse_cnt: 16'd0,
            burst_cnt: 16'd0, width: 8'(c.width), period: 16'(c.period)};
      tl.push_back(e);
      nb_eff  = (c.n_bursts == 0) ? 6 : c.n_bursts;
      run_len = c.n_pulses * c.period;
      for (int b = 0; b < nb_eff; b++) begin
         for (int k = 0; k < run_len; k++) begin
            e.busy = 1'b1; e.gen_rst = 1'b0;
            e.pulse_cnt = 16'(k / c.period);
            e.burst_cnt = 16'(b);
            tl.push_back(e);
         end
         e.pulse_cnt = 16'd0;
         e.burst_cnt = 16'(b + 1);
         if (b == nb_eff - 1) begin
            if (c.n_bursts != 0) begin
               e.busy = 1'b0; e.gen_rst = 1'b1; e.done = 1'b1;
               tl.push_back(e);
               e.done = 1'b0;
               tl.push_back(e);
               tl.push_back(e);
            end
         end else if (c.gap != 0) begin
            e.gen_rst = 1'b1;
            for (int g = 0; g < c.gap; g++) tl.push_back(e);
`ifdef PULSE_BURST_TRIGGER_EN
            tl.push_back(e);
`endif
         end
      end
      if (stop_at >= 1 && stop_at <= tl.size() && tl[stop_at-1].busy) begin
         last = tl[stop_at-1];
         while (tl.size() > stop_at) void'(tl.pop_back());
         last.busy = 1'b0; last.gen_rst = 1'b1; last.done = 1'b0;
         repeat (3) tl.push_back(last);
      end
   endfunction

   function automatic cfg_t mk(input int w, input int p, input int np, input int nb, input int g);
      cfg_t c;
      c.width = w; c.period = p; c.n_pulses = np; c.n_bursts = nb; c.gap = g;
      return c;
   endfunction

   // Starts a sequence and records one observation per modelled cycle. While
   // the block is busy, start and cfg_* are scrambled and must be ignored.
   task automatic run_seq(input cfg_t c, input int stop_at);
      got.delete();
      @(negedge clk);
      cfg_width = 8'(c.width); cfg_period = 16'(c.period);
      cfg_n_pulses = 16'(c.n_pulses); cfg_n_bursts = 16'(c.n_bursts); cfg_gap = 16'(c.gap);
      start = 1'b1; stop = 1'b0;
      for (int i = 0; i < tl.size(); i++) begin
         @(negedge clk);
         got.push_back(sample());
         start = tl[i].busy ? 1'($urandom_range(1, 0)) : 1'b0;
         stop  = (i + 1 == stop_at);
         if (tl[i].busy) begin
            cfg_width = 8'($urandom); cfg_period = 16'($urandom);
            cfg_n_pulses = 16'($urandom); cfg_n_bursts = 16'($urandom); cfg_gap = 16'($urandom);
         end
      end
      start = 1'b0; stop = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      vectors++;
      if (sample() !== reset_exp) begin
         miscompares++;
         $display("FAIL reset_async got {%s} expected {%s}", fmt(sample()), fmt(reset_exp));
      end
      @(negedge clk); @(negedge clk);
      vectors++;
      if (sample() !== reset_exp) begin
         miscompares++;
         $display("FAIL reset_held got {%s} expected {%s}", fmt(sample()), fmt(reset_exp));
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int dc = -1;
      int exp_dc;
`ifdef PULSE_BURST_TRIGGER_EN
      exp_dc = 32;
`else
      exp_dc = 31;
`endif
      build_model(mk(2, 4, 3, 2, 5), 0);
      run_seq(mk(2, 4, 3, 2, 5), 0);
      for (int i = 0; i < tl.size(); i++) begin
         vectors++;
         if (got[i] !== tl[i]) begin
            miscompares++;
            $display("FAIL basic cycle %0d got {%s} expected {%s}", i + 1, fmt(got[i]), fmt(tl[i]));
         end
         if (got[i].done === 1'b1 && dc < 0) dc = i + 1;
      end
      vectors++;
      if (dc !== exp_dc) begin
         miscompares++;
         $display("FAIL basic_done_cycle got %0d expected %0d", dc, exp_dc);
      end
      hold_exp = tl[tl.size()-1];
   endtask

   task automatic test_back_to_back();
      int dc = -1;
      build_model(mk(2, 4, 3, 2, 0), 0);
      run_seq(mk(2, 4, 3, 2, 0), 0);
      for (int i = 0; i < tl.size(); i++) begin
         vectors++;
         if (got[i] !== tl[i]) begin
            miscompares++;
            $display("FAIL back_to_back cycle %0d got {%s} expected {%s}", i + 1, fmt(got[i]), fmt(tl[i]));
         end
         if (got[i].done === 1'b1 && dc < 0) dc = i + 1;
      end
      vectors++;
      if (dc !== 26) begin
         miscompares++;
         $display("FAIL back_to_back_done_cycle got %0d expected 26", dc);
      end
      hold_exp = tl[tl.size()-1];
   endtask

   task automatic test_reject();
      cfg_t bad[2];
      obs_t e;
      bad[0] = mk(5, 4, 0, 1, 0);
      bad[1] = mk(5, 0, 3, 1, 0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         cfg_width = 8'(bad[k].width); cfg_period = 16'(bad[k].period);
         cfg_n_pulses = 16'(bad[k].n_pulses); cfg_n_bursts = 16'(bad[k].n_bursts); cfg_gap = 16'(bad[k].gap);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         e = hold_exp; e.err = 1'b1;
         vectors++;
         if (sample() !== e) begin
            miscompares++;
            $display("FAIL reject%0d_err got {%s} expected {%s}", k, fmt(sample()), fmt(e));
         end
         @(negedge clk);
         vectors++;
         if (sample() !== hold_exp) begin
            miscompares++;
            $display("FAIL reject%0d_after got {%s} expected {%s}", k, fmt(sample()), fmt(hold_exp));
         end
      end
      // start and stop together: stop wins and nothing is latched.
      @(negedge clk);
      cfg_width = 8'd9; cfg_period = 16'd7; cfg_n_pulses = 16'd2; cfg_n_bursts = 16'd1; cfg_gap = 16'd1;
      start = 1'b1; stop = 1'b1;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      for (int k = 0; k < 2; k++) begin
         vectors++;
         if (sample() !== hold_exp) begin
            miscompares++;
            $display("FAIL start_with_stop cycle %0d got {%s} expected {%s}", k + 1, fmt(sample()), fmt(hold_exp));
         end
         @(negedge clk);
      end
   endtask

   task automatic test_abort();
      int stop_at;
      // Bursts are 6 RUN cycles, each followed by a 2-cycle gap. The stop is
      // driven in the third RUN cycle of the fourth burst.
`ifdef PULSE_BURST_TRIGGER_EN
      stop_at = 1 + 3 * (6 + 2 + 1) + 3;
`else
      stop_at = 1 + 3 * (6 + 2) + 3;
`endif
      build_model(mk(1, 3, 2, 0, 2), stop_at);
      run_seq(mk(1, 3, 2, 0, 2), stop_at);
      for (int i = 0; i < tl.size(); i++) begin
         vectors++;
         if (got[i] !== tl[i]) begin
            miscompares++;
            $display("FAIL abort cycle %0d got {%s} expected {%s}", i + 1, fmt(got[i]), fmt(tl[i]));
         end
      end
      vectors++;
      if (got[got.size()-1].burst_cnt !== 16'd3) begin
         miscompares++;
         $display("FAIL abort_burst_hold got %0d expected 3", got[got.size()-1].burst_cnt);
      end
      hold_exp = tl[tl.size()-1];
   endtask

   task automatic test_async_reset();
      // ARM in cycle 1, RUN in 2-3, GAP in 4-8. Reset is applied mid cycle 6.
      build_model(mk(3, 2, 1, 2, 5), 0);
      @(negedge clk);
      cfg_width = 8'd3; cfg_period = 16'd2; cfg_n_pulses = 16'd1; cfg_n_bursts = 16'd2; cfg_gap = 16'd5;
      start = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      vectors++;
      if (sample() !== tl[5]) begin
         miscompares++;
         $display("FAIL async_pre_gap got {%s} expected {%s}", fmt(sample()), fmt(tl[5]));
      end
      #1 rst = 1'b1;
      #1;
      vectors++;
      if (sample() !== reset_exp) begin
         miscompares++;
         $display("FAIL async_reset got {%s} expected {%s}", fmt(sample()), fmt(reset_exp));
      end
      #1 rst = 1'b0;
      hold_exp = reset_exp;
      build_model(mk(7, 3, 2, 2, 1), 0);
      run_seq(mk(7, 3, 2, 2, 1), 0);
      for (int i = 0; i < tl.size(); i++) begin
         vectors++;
         if (got[i] !== tl[i]) begin
            miscompares++;
            $display("FAIL async_restart cycle %0d got {%s} expected {%s}", i + 1, fmt(got[i]), fmt(tl[i]));
         end
      end
      hold_exp = tl[tl.size()-1];
   endtask

   task automatic test_random();
      cfg_t c;
      int   stop_at;
      for (int n = 0; n < 12; n++) begin
         c = mk(int'($urandom_range(255, 1)), int'($urandom_range(5, 1)), int'($urandom_range(4, 1)),
                int'($urandom_range(3, 0)), int'($urandom_range(4, 0)));
         stop_at = 0;
         if (c.n_bursts == 0 || $urandom_range(2, 0) == 0) begin
            build_model(c, 0);
            stop_at = int'($urandom_range(tl.size(), 1));
         end
         build_model(c, stop_at);
         run_seq(c, stop_at);
         for (int i = 0; i < tl.size(); i++) begin
            vectors++;
            if (got[i] !== tl[i]) begin
               miscompares++;
               $display("FAIL random%0d cycle %0d got {%s} expected {%s}", n, i + 1, fmt(got[i]), fmt(tl[i]));
            end
         end
         hold_exp = tl[tl.size()-1];
      end
   endtask

`ifdef PULSE_BURST_TRIGGER_EN
   task automatic test_trigger();
      obs_t e;
      @(negedge clk);
      cfg_width = 8'd2; cfg_period = 16'd4; cfg_n_pulses = 16'd3; cfg_n_bursts = 16'd1; cfg_gap = 16'd0;
      trig = 1'b0; start = 1'b1;
      e = '{busy: 1'b1, gen_rst: 1'b1, done: 1'b0, err: 1'b0, pulse_cnt: 16'd0,
            burst_cnt: 16'd0, width: 8'd2, period: 16'd4};
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         start = 1'b0;
         vectors++;
         if (sample() !== e) begin
            miscompares++;
            $display("FAIL trig_arm cycle %0d got {%s} expected {%s}", c, fmt(sample()), fmt(e));
         end
         if (c == 10) trig = 1'b1;
      end
      @(negedge clk);
      e.gen_rst = 1'b0;
      vectors++;
      if (sample() !== e) begin
         miscompares++;
         $display("FAIL trig_run got {%s} expected {%s}", fmt(sample()), fmt(e));
      end
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      e.busy = 1'b0; e.gen_rst = 1'b1;
      vectors++;
      if (sample() !== e) begin
         miscompares++;
         $display("FAIL trig_stop got {%s} expected {%s}", fmt(sample()), fmt(e));
      end
      hold_exp = e;
   endtask
`endif

   initial begin
      reset_exp = '{busy: 1'b0, gen_rst: 1'b1, done: 1'b0, err: 1'b0, pulse_cnt: 16'd0,
                    burst_cnt: 16'd0, width: 8'd0, period: 16'd0};
      hold_exp = reset_exp;
      rst = 1'b1; start = 1'b0; stop = 1'b0;
`ifdef PULSE_BURST_TRIGGER_EN
      trig = 1'b1;
`endif
      cfg_width = '0; cfg_period = '0; cfg_n_pulses = '0; cfg_n_bursts = '0; cfg_gap = '0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_reject();
      test_abort();
      test_async_reset();
      test_random();
`ifdef PULSE_BURST_TRIGGER_EN
      test_trigger();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
